ad9643_spi_slave: RTL and testbench
===================================

# ad9643_spi_slave

SPI front end of the AD9643 simulation model: it decodes the 3-wire SPI protocol (CSB, SCLK, bidirectional SDIO) into single-cycle register-file accesses. It sits directly upstream of the 8-bit x 8192-entry register file. It drives `reg_write`, `reg_addr` and `reg_wrdata` into that file and serialises `reg_rddata` back onto SDIO. All SPI inputs are oversampled in the `clk` domain, so `clk` frequency must be at least 8x SCLK.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flops on `spi_csb`, `spi_sclk` and `spi_sdio_i` (minimum 2).
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  reset, synchronous, active-high; clock clk.
- `spi_csb`  in  1  chip select, active low, asynchronous to clk.
- `spi_sclk`  in  1  SPI clock, idle low, asynchronous.
- `spi_sdio_i`  in  1  SDIO input, sampled on SCLK rising edge.
- `spi_sdio_o`  out  1  SDIO read data, changes after SCLK falling edge.
- `spi_sdio_oe`  out  1  SDIO output enable; high only while read data is being driven.
- `reg_write`  out  1  one-clk write strobe to the register file.
- `reg_addr`  out  13  register address; also selects `reg_rddata`.
- `reg_wrdata`  out  8  write data, valid while `reg_write` is high.
- `reg_rddata`  in  8  combinational read data for `reg_addr`.
- `busy`  out  1  high while a transaction is active (synchronised CSB low).
- `frame_err`  out  1  one-clk pulse when CSB rises mid-instruction or mid-byte.

## Operation
- Synchronise CSB, SCLK and SDIO through `SYNC_STAGES` flops. SCLK rise and fall are detected from the last two synchronised samples. Only the synchronised signals are used internally.
- The instruction is 16 bits, MSB first:
  - bit15 R/nW (1 = read).
  - bits14:13 W1:W0 (00 = 1 byte, 01 = 2, 10 = 3, 11 = streaming until CSB).
  - bits12:0 start address.
- States:
  - IDLE: on CSB falling edge, clear `bit_cnt`, go to INSTR.
  - INSTR: shift SDIO on each SCLK rise. After the 16th rise, load `reg_addr` and `bytes_left`, then go to WR_DATA or RD_DATA.
  - WR_DATA: shift 8 bits. After the 8th rise, strobe the write, then step the address.
  - RD_DATA: shift out 8 bits, then step the address and reload.
  - DONE: entered after the final byte of a non-streaming transfer. All SCLK edges are ignored until CSB goes high.
- From any state, CSB high returns the block to IDLE on the next clk. An aborted partial byte is never written. `frame_err` pulses if the INSTR count is nonzero or the data `bit_cnt` is nonzero.
- Address steps by decrementing (MSB-first descending mode) and wraps modulo 2^13: 0x0000 -> 0x1FFF.
- Read shift register:
  - Load from `reg_rddata` two clks after the rise that completed the instruction or the previous data byte.
  - On each SCLK fall in RD_DATA, `spi_sdio_o` <= shift[7] and the register shifts left.
  - `spi_sdio_oe` = 1 from the first fall of the data phase until CSB high or DONE.
- SDIO input is ignored in RD_DATA. Writes never alter read data in flight.

## Timing
- Reset values:
  - `spi_sdio_o`, `spi_sdio_oe`, `reg_write`, `busy` and `frame_err` are all 0.
  - `reg_addr` = 0x0000 and `reg_wrdata` = 0x00.
  - State is IDLE; all counters are cleared.
- Reset mid-transaction aborts immediately with no write and no `frame_err`. The block waits for a fresh CSB fall: if CSB is still low when reset releases, the block stays in IDLE.
- Write timing, with cycle N = clk in which the 8th data-bit rise is detected:
  - N+1: `reg_write` = 1, with `reg_addr` and `reg_wrdata` valid.
  - N+2: `reg_addr` decrements.
- Instruction timing, with cycle N = clk in which the 16th instruction rise is detected: `reg_addr` is valid at N+1 and the read shift register loads at N+2.
- `reg_write` is never high for two consecutive clks.
- Input-to-detected-edge latency is `SYNC_STAGES` + 1 clks.
- `busy` follows synchronised CSB, delayed by one clk.

## Test plan
- Write 1 byte, instruction 0x000B, data 0x05 -> exactly one `reg_write` pulse with addr 0x00B and data 0x05; `spi_sdio_oe` stays 0.
- Write 3 bytes, instruction 0x401A, data 0xAA, 0xBB, 0xCC -> writes to 0x01A = 0xAA, 0x019 = 0xBB, 0x018 = 0xCC; no further writes on extra SCLKs.
- Streaming write, instruction 0x6001, data 0x11, 0x22, 0x33 -> writes to 0x0001, 0x0000, 0x1FFF (wrap).
- Read 2 bytes from 0x0D with `reg_rddata` model holding 0x0D = 0x5A and 0x0C = 0x3C -> bits on `spi_sdio_o`, sampled at SCLK rise, are 0x5A then 0x3C; `spi_sdio_oe` drops within `SYNC_STAGES` + 2 clks of CSB high.
- CSB raised after 5 data bits of a write -> no `reg_write`, one `frame_err` pulse, state IDLE; the next transaction works normally.
- Reset asserted during the second byte of a 3-byte write -> only the first byte written; all outputs return to their reset values.

Source files
------------

// File: rtl/ad9643_spi_slave.sv
// rtl/ad9643_spi_slave.sv - 3-wire SPI slave decoding AD9643 transactions into register-file accesses
module ad9643_spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_csb,
    input  logic        spi_sclk,
    input  logic        spi_sdio_i,
    output logic        spi_sdio_o,
    output logic        spi_sdio_oe,
    output logic        reg_write,
    output logic [12:0] reg_addr,
    output logic [7:0]  reg_wrdata,
    input  logic [7:0]  reg_rddata,
    output logic        busy,
    output logic        frame_err
);

    typedef enum logic [2:0] {IDLE, INSTR, WR_DATA, RD_DATA, DONE} state_t;

    // CSB and SCLK carry one extra flop so edges come from the last two synchronised samples.
    // CSB resets low so a CSB held low across reset never looks like a fresh falling edge.
    logic [SYNC_STAGES:0]   csb_sync_q;
    logic [SYNC_STAGES:0]   sclk_sync_q;
    logic [SYNC_STAGES-1:0] sdio_sync_q;

    logic csb_s, csb_p, sclk_s, sclk_p, sdio_s;
    logic csb_fall, sclk_rise, sclk_fall;

    state_t      state_q;
    logic [3:0]  bit_cnt_q;
    logic [14:0] instr_q;
    logic [6:0]  wr_shift_q;
    logic [7:0]  rd_shift_q;
    logic [1:0]  bytes_left_q;
    logic        stream_q;
    logic        load_pending_q;
    logic        step_pending_q;
    logic        sdio_o_q;
    logic        sdio_oe_q;
    logic        reg_write_q;
    logic [12:0] reg_addr_q;
    logic [7:0]  reg_wrdata_q;
    logic        busy_q;
    logic        frame_err_q;

    // Synchronise the asynchronous SPI pins into the clk domain
    always_ff @(posedge clk) begin
        if (reset) begin
            csb_sync_q  <= '0;
            sclk_sync_q <= '0;
            sdio_sync_q <= '0;
        end else begin
            csb_sync_q  <= {csb_sync_q[SYNC_STAGES-1:0], spi_csb};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-1:0], spi_sclk};
            sdio_sync_q <= {sdio_sync_q[SYNC_STAGES-2:0], spi_sdio_i};
        end
    end

    assign csb_s     = csb_sync_q[SYNC_STAGES-1];
    assign csb_p     = csb_sync_q[SYNC_STAGES];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign sclk_p    = sclk_sync_q[SYNC_STAGES];
    assign sdio_s    = sdio_sync_q[SYNC_STAGES-1];
    assign csb_fall  = ~csb_s & csb_p;
    assign sclk_rise = sclk_s & ~sclk_p;
    assign sclk_fall = ~sclk_s & sclk_p;

    // Transaction FSM with registered register-file and SDIO outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            instr_q        <= '0;
            wr_shift_q     <= '0;
            rd_shift_q     <= '0;
            bytes_left_q   <= '0;
            stream_q       <= 1'b0;
            load_pending_q <= 1'b0;
            step_pending_q <= 1'b0;
            sdio_o_q       <= 1'b0;
            sdio_oe_q      <= 1'b0;
            reg_write_q    <= 1'b0;
            reg_addr_q     <= '0;
            reg_wrdata_q   <= '0;
            busy_q         <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            reg_write_q <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= ~csb_s;

            // Write address steps the clk after the strobe so the file sees a stable address.
            if (step_pending_q) begin
                reg_addr_q     <= reg_addr_q - 13'd1;
                step_pending_q <= 1'b0;
            end
            // Read data is captured one clk after the address settles.
            if (load_pending_q) begin
                rd_shift_q     <= reg_rddata;
                load_pending_q <= 1'b0;
            end

            if (state_q != IDLE && csb_s) begin
                frame_err_q    <= (state_q == INSTR || state_q == WR_DATA || state_q == RD_DATA)
                                  && (bit_cnt_q != 4'd0);
                state_q        <= IDLE;
                bit_cnt_q      <= '0;
                sdio_oe_q      <= 1'b0;
                load_pending_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (csb_fall) begin
                            bit_cnt_q <= '0;
                            state_q   <= INSTR;
                        end
                    end
                    INSTR: begin
                        if (sclk_rise) begin
                            instr_q <= {instr_q[13:0], sdio_s};
                            if (bit_cnt_q == 4'd15) begin
                                bit_cnt_q    <= '0;
                                reg_addr_q   <= {instr_q[11:0], sdio_s};
                                bytes_left_q <= instr_q[13:12];
                                stream_q     <= &instr_q[13:12];
                                if (instr_q[14]) begin
                                    state_q        <= RD_DATA;
                                    load_pending_q <= 1'b1;
                                end else begin
                                    state_q <= WR_DATA;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (sclk_rise) begin
                            wr_shift_q <= {wr_shift_q[5:0], sdio_s};
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_q      <= '0;
                                reg_write_q    <= 1'b1;
                                reg_wrdata_q   <= {wr_shift_q, sdio_s};
                                step_pending_q <= 1'b1;
                                if (!stream_q && bytes_left_q == 2'd0) begin
                                    state_q <= DONE;
                                end else if (!stream_q) begin
                                    bytes_left_q <= bytes_left_q - 2'd1;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (sclk_fall) begin
                            sdio_o_q   <= rd_shift_q[7];
                            rd_shift_q <= {rd_shift_q[6:0], 1'b0};
                            sdio_oe_q  <= 1'b1;
                        end else if (sclk_rise) begin
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_q <= '0;
                                if (!stream_q && bytes_left_q == 2'd0) begin
                                    state_q   <= DONE;
                                    sdio_oe_q <= 1'b0;
                                end else begin
                                    reg_addr_q     <= reg_addr_q - 13'd1;
                                    load_pending_q <= 1'b1;
                                    if (!stream_q) begin
                                        bytes_left_q <= bytes_left_q - 2'd1;
                                    end
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    DONE: begin
                        sdio_oe_q <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign spi_sdio_o  = sdio_o_q;
    assign spi_sdio_oe = sdio_oe_q;
    assign reg_write   = reg_write_q;
    assign reg_addr    = reg_addr_q;
    assign reg_wrdata  = reg_wrdata_q;
    assign busy        = busy_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ad9643_spi_slave.sv
// tb/tb_ad9643_spi_slave.sv - scoreboard testbench for ad9643_spi_slave
module tb_ad9643_spi_slave;

    localparam int SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_csb = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_sdio_i = 1'b0;
    logic        spi_sdio_o;
    logic        spi_sdio_oe;
    logic        reg_write;
    logic [12:0] reg_addr;
    logic [7:0]  reg_wrdata;
    logic [7:0]  reg_rddata;
    logic        busy;
    logic        frame_err;

    logic [7:0]  mem [0:8191];
    logic [20:0] exp_wr_q [$];
    logic [7:0]  exp_rd_q [$];

    int vectors = 0;
    int miscompares = 0;
    int wr_count = 0;
    int fe_count = 0;
    bit oe_seen = 1'b0;
    bit prev_wr = 1'b0;
    logic [12:0] prev_addr = '0;

    ad9643_spi_slave #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk         (clk),
        .reset       (reset),
        .spi_csb     (spi_csb),
        .spi_sclk    (spi_sclk),
        .spi_sdio_i  (spi_sdio_i),
        .spi_sdio_o  (spi_sdio_o),
        .spi_sdio_oe (spi_sdio_oe),
        .reg_write   (reg_write),
        .reg_addr    (reg_addr),
        .reg_wrdata  (reg_wrdata),
        .reg_rddata  (reg_rddata),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    assign reg_rddata = mem[reg_addr];

    // Register-file model and write scoreboard
    always @(negedge clk) begin
        logic [20:0] exp;
        if (reset) begin
            prev_wr = 1'b0;
        end else begin
            if (prev_wr) begin
                vectors++;
                if (reg_write !== 1'b0 || reg_addr !== prev_addr - 13'd1) begin
                    miscompares++;
                    $display("FAIL addr_step: write=%b addr=%h, required write=0 addr=%h",
                             reg_write, reg_addr, prev_addr - 13'd1);
                end
            end
            if (reg_write === 1'b1) begin
                vectors++;
                wr_count++;
                if (exp_wr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write: addr=%h data=%h, required no write", reg_addr, reg_wrdata);
                end else begin
                    exp = exp_wr_q.pop_front();
                    if ({reg_addr, reg_wrdata} !== exp) begin
                        miscompares++;
                        $display("FAIL write: addr=%h data=%h, required addr=%h data=%h",
                                 reg_addr, reg_wrdata, exp[20:8], exp[7:0]);
                    end
                end
                mem[reg_addr] = reg_wrdata;
            end
            prev_wr   = (reg_write === 1'b1);
            prev_addr = reg_addr;
            if (frame_err === 1'b1) fe_count++;
            if (spi_sdio_oe === 1'b1) oe_seen = 1'b1;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_wr_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            spi_sdio_i = b[i];
            wait_clks(5);
            spi_sclk = 1'b1;
            wait_clks(5);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_wr_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_sdio_i = b[i];
            wait_clks(5);
            spi_sclk = 1'b1;
            wait_clks(5);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_rd_byte(output logic [7:0] b, output bit oe_ok);
        oe_ok = 1'b1;
        b = '0;
        for (int i = 7; i >= 0; i--) begin
            spi_sdio_i = 1'($urandom);
            wait_clks(5);
            b = {b[6:0], spi_sdio_o};
            if (spi_sdio_oe !== 1'b1) oe_ok = 1'b0;
            spi_sclk = 1'b1;
            wait_clks(5);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_begin(input logic [15:0] instr);
        spi_csb = 1'b0;
        wait_clks(4);
        spi_wr_byte(instr[15:8]);
        spi_wr_byte(instr[7:0]);
    endtask

    task automatic spi_end();
        wait_clks(5);
        spi_csb = 1'b1;
        wait_clks(10);
    endtask

    task automatic check_idle_outputs(input string name);
        vectors++;
        if ({spi_sdio_o, spi_sdio_oe, reg_write, busy, frame_err, reg_addr, reg_wrdata} !== 28'd0) begin
            miscompares++;
            $display("FAIL %s: sdio_o=%b oe=%b wr=%b busy=%b ferr=%b addr=%h wdata=%h, required all zero",
                     name, spi_sdio_o, spi_sdio_oe, reg_write, busy, frame_err, reg_addr, reg_wrdata);
        end
    endtask

    task automatic check_drained(input string name, input int wr_before, input int wr_exp);
        vectors++;
        if (exp_wr_q.size() != 0 || wr_count - wr_before != wr_exp) begin
            miscompares++;
            $display("FAIL %s: writes=%0d pending=%0d, required writes=%0d pending=0",
                     name, wr_count - wr_before, exp_wr_q.size(), wr_exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_clks(5);
        check_idle_outputs("reset_state");
        reset = 1'b0;
        wait_clks(10);
    endtask

    task automatic test_write_one();
        int w0 = wr_count;
        oe_seen = 1'b0;
        exp_wr_q.push_back({13'h000B, 8'h05});
        spi_begin(16'h000B);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_active: busy=%b, required 1", busy);
        end
        spi_wr_byte(8'h05);
        spi_end();
        check_drained("write_one", w0, 1);
        vectors++;
        if (oe_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL write_one_oe: oe seen=%b, required 0", oe_seen);
        end
    endtask

    task automatic test_write_three();
        int w0 = wr_count;
        exp_wr_q.push_back({13'h001A, 8'hAA});
        exp_wr_q.push_back({13'h0019, 8'hBB});
        exp_wr_q.push_back({13'h0018, 8'hCC});
        spi_begin(16'h401A);
        spi_wr_byte(8'hAA);
        spi_wr_byte(8'hBB);
        spi_wr_byte(8'hCC);
        spi_wr_byte(8'hDD);
        spi_end();
        check_drained("write_three", w0, 3);
        vectors++;
        if (reg_addr !== 13'h0017) begin
            miscompares++;
            $display("FAIL write_three_addr: addr=%h, required 0017", reg_addr);
        end
    endtask

    task automatic test_stream_wrap();
        int w0 = wr_count;
        int f0 = fe_count;
        exp_wr_q.push_back({13'h0001, 8'h11});
        exp_wr_q.push_back({13'h0000, 8'h22});
        exp_wr_q.push_back({13'h1FFF, 8'h33});
        spi_begin(16'h6001);
        spi_wr_byte(8'h11);
        spi_wr_byte(8'h22);
        spi_wr_byte(8'h33);
        spi_end();
        check_drained("stream_wrap", w0, 3);
        vectors++;
        if (fe_count != f0) begin
            miscompares++;
            $display("FAIL stream_ferr: pulses=%0d, required 0", fe_count - f0);
        end
    endtask

    task automatic test_read_two();
        logic [7:0] got, exp;
        bit oe_ok;
        mem[13'h000D] = 8'h5A;
        mem[13'h000C] = 8'h3C;
        exp_rd_q.push_back(8'h5A);
        exp_rd_q.push_back(8'h3C);
        spi_begin(16'hA00D);
        for (int k = 0; k < 2; k++) begin
            spi_rd_byte(got, oe_ok);
            exp = exp_rd_q.pop_front();
            vectors++;
            if (got !== exp || !oe_ok) begin
                miscompares++;
                $display("FAIL read_byte%0d: data=%h oe_ok=%b, required data=%h oe_ok=1", k, got, oe_ok, exp);
            end
        end
        wait_clks(5);
        spi_csb = 1'b1;
        wait_clks(SYNC_STAGES + 2);
        vectors++;
        if (spi_sdio_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL read_oe_release: oe=%b, required 0", spi_sdio_oe);
        end
        wait_clks(10);
    endtask

    task automatic test_abort();
        int w0 = wr_count;
        int f0 = fe_count;
        spi_begin(16'h0030);
        spi_wr_bits(8'hE7, 5);
        spi_end();
        vectors++;
        if (wr_count != w0 || fe_count - f0 != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort: writes=%0d ferr_cycles=%0d busy=%b, required 0 1 0",
                     wr_count - w0, fe_count - f0, busy);
        end
        exp_wr_q.push_back({13'h0040, 8'h77});
        spi_begin(16'h0040);
        spi_wr_byte(8'h77);
        spi_end();
        check_drained("after_abort", w0, 1);
    endtask

    task automatic test_reset_mid();
        int w0 = wr_count;
        int f0 = fe_count;
        exp_wr_q.push_back({13'h0050, 8'h12});
        spi_begin(16'h4050);
        spi_wr_byte(8'h12);
        spi_wr_bits(8'h34, 3);
        reset = 1'b1;
        wait_clks(3);
        check_idle_outputs("reset_mid_state");
        reset = 1'b0;
        wait_clks(5);
        spi_wr_byte(8'h56);
        spi_wr_byte(8'h78);
        spi_end();
        check_drained("reset_mid", w0, 1);
        vectors++;
        if (fe_count != f0) begin
            miscompares++;
            $display("FAIL reset_mid_ferr: pulses=%0d, required 0", fe_count - f0);
        end
    endtask

    task automatic test_back_to_back();
        int w0 = wr_count;
        exp_wr_q.push_back({13'h0123, 8'h9C});
        exp_wr_q.push_back({13'h0122, 8'h3E});
        spi_begin(16'h2123);
        spi_wr_byte(8'h9C);
        spi_wr_byte(8'h3E);
        spi_end();
        exp_wr_q.push_back({13'h1ABC, 8'hF0});
        spi_begin(16'h1ABC);
        spi_wr_byte(8'hF0);
        spi_end();
        check_drained("back_to_back", w0, 3);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'(i * 7 + 3);
        test_reset();
        test_write_one();
        test_write_three();
        test_stream_wrap();
        test_read_two();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
